// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int DATA_BITS              = 8;
   localparam int CYCLES_PER_BIT_DEFAULT = 434;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled by the system clock; bytes leave on a
// valid/ready stream and a byte completing while the previous one is still held is dropped.
module uart_rx
   import uart_pkg::*;
#(
   parameter int cycles_per_bit = CYCLES_PER_BIT_DEFAULT  // must be >= 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 tready,
   output logic                 tvalid,
   output logic [DATA_BITS-1:0] tdata,
   output logic                 overflow
);

   localparam int                CNT_W       = $clog2(cycles_per_bit + 1);
   localparam logic [CNT_W-1:0]  FULL_RELOAD = CNT_W'(cycles_per_bit - 1);
   localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(cycles_per_bit / 2 - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [2:0]        LAST_BIT    = 3'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_e          state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2:0]           bit_idx_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic [DATA_BITS-1:0] shreg_d;
   logic                 done_q;
   logic                 tvalid_q;
   logic [DATA_BITS-1:0] tdata_q;
   logic                 overflow_q;

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (rx),
      .q_o (rx_s)
   );

   // New bits enter at the top so the first bit on the line ends up in bit 0.
   assign shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shreg_q    <= '0;
         done_q     <= 1'b0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         overflow_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  cnt_q   <= HALF_RELOAD;
                  state_q <= START;
               end
            end
            START: begin
               if (cnt_q == '0) begin
                  if (!rx_s) begin
                     cnt_q     <= FULL_RELOAD;
                     bit_idx_q <= '0;
                     state_q   <= DATA;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            DATA: begin
               if (cnt_q == '0) begin
                  shreg_q <= shreg_d;
                  cnt_q   <= FULL_RELOAD;
                  if (bit_idx_q == LAST_BIT) begin
                     state_q <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            STOP: begin
               if (cnt_q == '0) begin
                  // A low stop bit is a framing error: the byte is silently discarded.
                  done_q  <= rx_s;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // shreg_q cannot change before delivery: the next DATA sample is a full bit away.
         if (done_q) begin
            if (!tvalid_q || tready) begin
               tdata_q  <= shreg_q;
               tvalid_q <= 1'b1;
            end else begin
               overflow_q <= 1'b1;
            end
         end else if (tvalid_q && tready) begin
            tvalid_q <= 1'b0;
         end
      end
   end

   assign tvalid   = tvalid_q;
   assign tdata    = tdata_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx against a queue-based model of delivered bytes.
module tb_uart_rx;

   localparam int CPB       = 434;
   localparam int STOP_CHK  = CPB / 2 + 10;
   localparam int STOP_REST = CPB - STOP_CHK;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       tready;
   logic       tvalid;
   logic [7:0] tdata;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   logic [7:0] got[$];
   int         tv_cnt     = 0;
   int         ovf_cnt    = 0;
   int         linger_cnt = 0;
   bit         prev_xfer  = 1'b0;

   logic [7:0] exp_q[$];
   int         rd = 0;

   uart_rx #(.cycles_per_bit(CPB)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .tready   (tready),
      .tvalid   (tvalid),
      .tdata    (tdata),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Observer: records transfers, overflow pulses, and tvalid lingering after a transfer.
   always @(negedge clk) begin
      if (rst) begin
         prev_xfer = 1'b0;
      end else begin
         if (tvalid) tv_cnt++;
         if (overflow) ovf_cnt++;
         if (prev_xfer && tvalid) linger_cnt++;
         prev_xfer = tvalid && tready;
         if (tvalid && tready) got.push_back(tdata);
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Drives start, data and the first part of the stop bit; returns after the stop sample point.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      rx = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(CPB);
      end
      rx = stop_ok;
      wait_cyc(STOP_CHK);
   endtask

   task automatic end_frame();
      rx = 1'b1;
      wait_cyc(STOP_REST);
   endtask

   task automatic check_rx(input string tag);
      int n;
      n = exp_q.size();
      chk({tag, "_count"}, got.size() - rd, n);
      for (int i = 0; i < n; i++) begin
         if (rd < got.size()) begin
            chk({tag, "_data"}, int'(got[rd]), int'(exp_q[i]));
            rd++;
         end
      end
      rd = got.size();
      exp_q.delete();
   endtask

   initial begin
      int         tv0;
      int         ovf0;
      int         nrx0;
      logic [7:0] b;
      bit         hold;

      rst    = 1'b1;
      rx     = 1'b1;
      tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", int'(tvalid), 0);
      chk("rst_tdata", int'(tdata), 0);
      chk("rst_overflow", int'(overflow), 0);
      #1;
      rst = 1'b0;

      // Low line right after reset: only a glitch, never a byte.
      tv0 = tv_cnt;
      rx  = 1'b0;
      wait_cyc(5);
      rx = 1'b1;
      wait_cyc(CPB);
      chk("low_after_rst_tvalid", tv_cnt - tv0, 0);

      // Single byte with consumer ready.
      tready = 1'b1;
      ovf0   = ovf_cnt;
      send_frame(8'd77, 1'b1);
      exp_q.push_back(8'd77);
      end_frame();
      wait_cyc(10);
      check_rx("single");
      chk("single_linger", linger_cnt, 0);
      chk("single_tvalid_low", int'(tvalid), 0);
      chk("single_ovf", ovf_cnt - ovf0, 0);

      // Consumer stalled: second byte is dropped and flagged before its stop bit ends.
      tready = 1'b0;
      ovf0   = ovf_cnt;
      send_frame(8'd77, 1'b1);
      exp_q.push_back(8'd77);
      end_frame();
      chk("stall_tvalid", int'(tvalid), 1);
      chk("stall_tdata", int'(tdata), 77);
      chk("stall_ovf0", ovf_cnt - ovf0, 0);
      send_frame(8'd77, 1'b1);
      chk("stall_ovf1", ovf_cnt - ovf0, 1);
      chk("stall_tdata_kept", int'(tdata), 77);
      end_frame();
      tready = 1'b1;
      wait_cyc(5);
      check_rx("stall");
      chk("stall_ovf_final", ovf_cnt - ovf0, 1);

      // Short glitch on an idle line.
      tv0  = tv_cnt;
      nrx0 = got.size();
      rx   = 1'b0;
      wait_cyc(3);
      rx = 1'b1;
      wait_cyc(CPB);
      chk("glitch_tvalid", tv_cnt - tv0, 0);
      chk("glitch_bytes", got.size() - nrx0, 0);

      // Framing error, then a good frame.
      tv0  = tv_cnt;
      ovf0 = ovf_cnt;
      send_frame(8'hA5, 1'b0);
      end_frame();
      wait_cyc(CPB);
      chk("frame_err_tvalid", tv_cnt - tv0, 0);
      chk("frame_err_ovf", ovf_cnt - ovf0, 0);
      send_frame(8'h3C, 1'b1);
      exp_q.push_back(8'h3C);
      end_frame();
      wait_cyc(5);
      check_rx("after_frame_err");

      // Back-to-back frames.
      ovf0 = ovf_cnt;
      send_frame(8'h01, 1'b1);
      exp_q.push_back(8'h01);
      end_frame();
      send_frame(8'hFF, 1'b1);
      exp_q.push_back(8'hFF);
      end_frame();
      wait_cyc(5);
      check_rx("b2b");
      chk("b2b_ovf", ovf_cnt - ovf0, 0);

      // Reset in the middle of a frame discards it.
      tv0 = tv_cnt;
      rx  = 1'b0;
      wait_cyc(CPB);
      rx = 1'b1;
      wait_cyc(2 * CPB);
      rst = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(2 * CPB);
      chk("midreset_tvalid", tv_cnt - tv0, 0);
      chk("midreset_tdata", int'(tdata), 0);
      check_rx("midreset");

      // Random bytes, sometimes held until after the stop bit.
      ovf0 = ovf_cnt;
      for (int k = 0; k < 4; k++) begin
         b      = 8'($urandom);
         hold   = 1'($urandom_range(0, 1));
         tready = !hold;
         send_frame(b, 1'b1);
         exp_q.push_back(b);
         end_frame();
         if (hold) begin
            chk("rand_hold_tvalid", int'(tvalid), 1);
            chk("rand_hold_tdata", int'(tdata), int'(b));
            tready = 1'b1;
         end
         wait_cyc(3 + $urandom_range(0, 50));
      end
      check_rx("rand");
      chk("rand_ovf", ovf_cnt - ovf0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
